sort_net_pipe: RTL and testbench
================================

Name: sort_net_pipe

Overview:
Parametrised, pipelined sorting network for N = 2**LOG2_N keys of DATA_W bits each. It is the registered, handshaked successor to the combinational 16-key sorters. It uses a bitonic network with one register stage per compare layer and accepts one full vector per cycle. It adds per-vector ascending/descending mode, optional signed compare, valid/ready backpressure with bubble collapsing, and an occupancy count.

Parameters:
DATA_W, 32, width of one key in bits
LOG2_N, 4, log2 of key count; N = 2**LOG2_N, legal range 1..6
SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data and in_desc are valid
in_ready  output  1  block accepts a vector this cycle
in_data  input  DATA_W*N  key i at bits [(i+1)*DATA_W-1 : i*DATA_W]
in_desc  input  1  0 = ascending (key 0 smallest), 1 = descending (key 0 largest)
out_valid  output  1  out_data and out_desc are valid
out_ready  input  1  downstream accepts the output this cycle
out_data  output  DATA_W*N  sorted vector, same packing as in_data
out_desc  output  1  in_desc carried with the vector
occupancy  output  ceil(log2(S+1))  number of valid pipeline stages, 0..S

Behaviour:
- S = LOG2_N*(LOG2_N+1)/2 stages (N=16 gives S=10). Each stage is one full bitonic compare layer of N/2 compare-exchange units followed by a register holding data, desc and a valid bit.
- Compare-exchange direction per unit is the standard bitonic direction for its block, XORed with the vector's desc bit. Sorting descending therefore costs no extra stage.
- Compare: SIGNED=0 treats keys as unsigned; SIGNED=1 treats them as two's complement. Equal keys may be swapped; the output multiset equals the input multiset bit-exactly.
- Handshake: a transfer occurs on a cycle where valid and ready are both high. in_data and in_desc are sampled only on an input transfer. out_data and out_desc hold stable while out_valid=1 and out_ready=0.
- Bubble collapse: stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready=1 or it is empty. in_ready equals "stage 0 advances". A full pipeline with out_ready=0 gives in_ready=0. A bubble in any stage lets upstream stages move and keeps in_ready=1.
- A stage that advances without receiving new data clears its valid bit. Data registers of an empty stage are don't-care but must not affect outputs.
- Latency is S cycles from input transfer to out_valid when out_ready stays 1. Throughput is 1 vector per cycle sustained.
- occupancy counts stage valid bits. It updates on the same edge as the valid bits: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
- Ordering: vectors exit in acceptance order; none are dropped or duplicated.
- Reset: on a clk edge with rst=1, all stage valid bits clear, data registers clear to 0 and occupancy becomes 0. During that cycle and after it, out_valid=0, out_data=0 and out_desc=0. in_ready becomes 1 on the first cycle after rst deasserts.
- Reset mid-operation discards all in-flight vectors. No partial output appears.
- in_ready depends combinationally on out_ready; no other combinational input-to-output path exists.
- LOG2_N=1 degenerates to a single compare stage, S=1.

Test Plan:
- Reset check: rst high for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0; after release, in_ready=1.
- Ascending sort, N=16, DATA_W=32: input keys 15..0 (key i = 15-i), out_ready=1 -> exactly 10 cycles later out_valid=1 with key i = i, out_desc=0, in one cycle.
- Descending with duplicates: keys {5,5,0,FFFFFFFF,...} with in_desc=1, SIGNED=0 -> key 0 = FFFFFFFF, multiset preserved, out_desc=1. The same vector with SIGNED=1 -> FFFFFFFF (-1) sorts below 0 and 5.
- Backpressure: stream 12 random vectors back-to-back with out_ready=0 -> in_ready drops after 10 accepts, occupancy=10 and out_data stays stable. Then out_ready=1 -> all 12 vectors exit in order, each matching a reference sort.
- Bubble collapse: accept vectors at cycles 0 and 5 with out_ready=0 -> both advance to the tail. Occupancy=2 and in_ready stays 1 until 10 stages are filled.
- Mid-flight reset: 6 vectors in flight, rst pulsed for 1 cycle -> no out_valid afterward, occupancy=0, and the next vector sorts correctly with latency 10.

Source files
------------

// File: rtl/sort_net_pipe.sv
// sort_net_pipe: pipelined bitonic sorter, one compare layer per register stage, valid/ready with bubble collapse
module sort_net_pipe #(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 4,
  parameter int SIGNED = 0,
  localparam int N = 2 ** LOG2_N,
  localparam int S = LOG2_N * (LOG2_N + 1) / 2,
  localparam int OW = $clog2(S + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_desc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic                out_desc,
  output logic [OW-1:0]       occupancy
);
  function automatic int stage_pq(input int k);
    int s;
    s = 0;
    stage_pq = 0;
    for (int p = 0; p < LOG2_N; p++)
      for (int q = p; q >= 0; q--) begin
        if (s == k) stage_pq = p * 16 + q;
        s++;
      end
  endfunction
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
  endfunction
  // Bit p+1 of the lower index picks the bitonic block direction; desc flips every unit.
  function automatic logic [N*DATA_W-1:0] layer(input logic [N*DATA_W-1:0] x, input logic dn,
                                                input int p, input int q);
    logic [DATA_W-1:0] a, b;
    logic sw;
    layer = x;
    for (int i = 0; i < N; i++)
      if (((i >> q) & 1) == 0) begin
        a = x[i*DATA_W +: DATA_W];
        b = x[(i + (1 << q))*DATA_W +: DATA_W];
        sw = ((((i >> (p + 1)) & 1) == 1) ^ dn) ? gt(b, a) : gt(a, b);
        layer[i*DATA_W +: DATA_W] = sw ? b : a;
        layer[(i + (1 << q))*DATA_W +: DATA_W] = sw ? a : b;
      end
  endfunction
  logic [N*DATA_W-1:0] sd [S];
  logic [S-1:0] sv, sdn, adv;
  logic [OW-1:0] occ;
  always_comb begin
    logic a;
    a = out_ready;
    adv = '0;
    for (int k = S - 1; k >= 0; k--) begin
      a = ~sv[k] | a;
      adv[k] = a;
    end
  end
  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int PQ = stage_pq(k);
    logic [N*DATA_W-1:0] x, d_q;
    logic dn, v, v_q, dn_q;
    if (k == 0) begin : g_h
      assign x = in_data;
      assign dn = in_desc;
      assign v = in_valid;
    end else begin : g_b
      assign x = sd[k-1];
      assign dn = sdn[k-1];
      assign v = sv[k-1];
    end
    always_ff @(posedge clk)
      if (rst) begin
        v_q <= 1'b0;
        dn_q <= 1'b0;
        d_q <= '0;
      end else if (adv[k]) begin
        v_q <= v;
        dn_q <= dn;
        d_q <= layer(x, dn, PQ / 16, PQ % 16);
      end
    assign sd[k] = d_q;
    assign sv[k] = v_q;
    assign sdn[k] = dn_q;
  end
  always_ff @(posedge clk)
    if (rst) occ <= '0;
    else occ <= occ + OW'(in_valid & adv[0]) - OW'(sv[S-1] & out_ready);
  assign in_ready = adv[0];
  assign out_valid = sv[S-1];
  assign out_data = sv[S-1] ? sd[S-1] : '0;
  assign out_desc = sv[S-1] & sdn[S-1];
  assign occupancy = occ;
endmodule

// File: tb/tb_sort_net_pipe.sv
// tb_sort_net_pipe: directed vectors plus streaming/backpressure/reset sequences for sort_net_pipe
module tb_sort_net_pipe;
  typedef struct {
    logic [511:0] d;
    logic dn;
    logic sg;
    logic [511:0] e;
    string nm;
  } tv_t;
  logic clk = 0, rst = 1, in_valid = 0, in_desc = 0, out_ready = 1;
  logic [511:0] in_data = '0;
  logic in_ready, out_valid, out_desc, s_in_ready, s_out_valid, s_out_desc;
  logic [511:0] out_data, s_out_data;
  logic [3:0] occupancy, s_occ;
  int nvec = 0, nerr = 0;
  logic [511:0] vq[$], eq[$];
  logic dq[$], edq[$];
  tv_t tv[6];
  always #5 clk = ~clk;
  sort_net_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_desc(out_desc), .occupancy(occupancy));
  sort_net_pipe #(.SIGNED(1)) sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_desc(in_desc), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_desc(s_out_desc), .occupancy(s_occ));
  function automatic logic [511:0] pk(input logic [31:0] k[16]);
    for (int i = 0; i < 16; i++) pk[i*32 +: 32] = k[i];
  endfunction
  function automatic logic lt(input logic [31:0] a, input logic [31:0] b, input logic sg);
    lt = sg ? ($signed(a) < $signed(b)) : (a < b);
  endfunction
  function automatic logic [511:0] rs(input logic [511:0] d, input logic dn, input logic sg);
    logic [31:0] k[16];
    logic [31:0] t;
    for (int i = 0; i < 16; i++) k[i] = d[i*32 +: 32];
    for (int i = 1; i < 16; i++)
      for (int j = i; j > 0 && (dn ? lt(k[j-1], k[j], sg) : lt(k[j], k[j-1], sg)); j--) begin
        t = k[j];
        k[j] = k[j-1];
        k[j-1] = t;
      end
    rs = pk(k);
  endfunction
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input logic ordy);
    for (int c = 0; c < n; c++) begin
      out_ready = ordy;
      in_valid = vq.size() > 0;
      if (in_valid) begin
        in_data = vq[0];
        in_desc = dq[0];
      end
      #1;
      if (in_valid && in_ready) begin
        eq.push_back(rs(vq[0], dq[0], 1'b0));
        edq.push_back(dq[0]);
        void'(vq.pop_front());
        void'(dq.pop_front());
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          chk("stream_data", out_data, eq.pop_front());
          chk("stream_desc", out_desc, edq.pop_front());
        end
      end
      tick;
    end
    in_valid = 0;
  endtask
  task automatic drain(input int bound);
    for (int c = 0; c < bound && (vq.size() > 0 || eq.size() > 0); c++) run(1, 1'b1);
    chk("drain_left", vq.size() + eq.size(), 0);
  endtask
  task automatic push_rand(input int n);
    logic [511:0] v;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
      vq.push_back(v);
      dq.push_back(1'($urandom_range(0, 1)));
    end
  endtask
  task automatic lat(input tv_t t);
    int n;
    out_ready = 1;
    in_data = t.d;
    in_desc = t.dn;
    in_valid = 1;
    tick;
    in_valid = 0;
    n = 1;
    while (!(t.sg ? s_out_valid : out_valid) && n < 20) begin
      tick;
      n++;
    end
    chk({t.nm, "_latency"}, n, 10);
    chk({t.nm, "_data"}, t.sg ? s_out_data : out_data, t.e);
    chk({t.nm, "_desc"}, t.sg ? s_out_desc : out_desc, t.dn);
    tick;
    chk({t.nm, "_one_cycle"}, t.sg ? s_out_valid : out_valid, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] ka[16], kb[16], kd[16];
    logic [511:0] hold;
    ka = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    kb = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    kd = '{5, 5, 0, 32'hFFFFFFFF, 7, 7, 1, 2, 3, 3, 'h100, 0, 32'hFFFFFFFF, 9, 8, 6};
    tv[0] = '{pk(ka), 1'b0, 1'b0, pk(kb), "asc_rev"};
    tv[1] = '{pk(ka), 1'b1, 1'b0, pk(ka), "desc_rev"};
    kb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 'h100, 9, 8, 7, 7, 6, 5, 5, 3, 3, 2, 1, 0, 0};
    tv[2] = '{pk(kd), 1'b1, 1'b0, pk(kb), "dup_desc_u"};
    kb = '{'h100, 9, 8, 7, 7, 6, 5, 5, 3, 3, 2, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tv[3] = '{pk(kd), 1'b1, 1'b1, pk(kb), "dup_desc_s"};
    kb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 2, 3, 3, 5, 5, 6, 7, 7, 8, 9, 'h100};
    tv[4] = '{pk(kd), 1'b0, 1'b1, pk(kb), "dup_asc_s"};
    kb = '{0, 0, 1, 2, 3, 3, 5, 5, 6, 7, 7, 8, 9, 'h100, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tv[5] = '{pk(kd), 1'b0, 1'b0, pk(kb), "dup_asc_u"};
    rst = 1;
    in_valid = 1;
    in_data = tv[0].d;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_desc", out_desc, 1'b0);
      chk("rst_occupancy", occupancy, 0);
    end
    rst = 0;
    in_valid = 0;
    tick;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_occupancy", occupancy, 0);
    foreach (tv[i]) lat(tv[i]);
    push_rand(12);
    run(25, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_occupancy", occupancy, 10);
    chk("bp_accepted_left", vq.size(), 2);
    chk("bp_out_valid", out_valid, 1'b1);
    hold = out_data;
    run(3, 1'b0);
    chk("bp_hold", out_data, hold);
    drain(60);
    push_rand(1);
    run(5, 1'b0);
    push_rand(1);
    run(13, 1'b0);
    chk("bub_occupancy", occupancy, 2);
    chk("bub_in_ready", in_ready, 1'b1);
    chk("bub_head", out_data, eq[0]);
    push_rand(8);
    run(8, 1'b0);
    chk("bub_all_accepted", vq.size(), 0);
    chk("bub_full_occ", occupancy, 10);
    chk("bub_full_in_ready", in_ready, 1'b0);
    drain(40);
    push_rand(6);
    run(6, 1'b1);
    chk("mid_occupancy", occupancy, 6);
    rst = 1;
    tick;
    rst = 0;
    eq.delete();
    edq.delete();
    chk("mid_rst_occupancy", occupancy, 0);
    for (int i = 0; i < 15; i++) begin
      chk("mid_no_out_valid", out_valid, 1'b0);
      tick;
    end
    lat(tv[2]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
